mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Synthesizable memory-side responder for the req/wr/addr/dout/din/rdy random-access protocol driven by the GUPS `top` initiator.
- Services single outstanding reads and writes with fixed, parameterized latency, backed by an on-chip word array.
- Replaces the behavioural memory model, so `top` can be closed into a self-contained system for synthesis and emulation.
- Clears its array after reset so that expected contents are deterministic.

Parameters:
ADDR_W, 13, word-address bits used; DEPTH = 2**ADDR_W
DATA_W, 64, word width
RD_LAT, 2, cycles from req capture to rdy for reads (legal range >= 2)
WR_LAT, 5, cycles from req capture to rdy for writes (legal range >= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
busy  out  1  high during post-reset array clear
req  in  1  initiator request; held high until rdy
wr  in  1  1 = write, 0 = read; stable while req high
addr  in  64  word address; stable while req high
wdata  in  DATA_W  write data (initiator dout); stable while req high
rdata  out  DATA_W  read data (initiator din)
rdy  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with rdy when address out of range
rd_cnt  out  32  completed reads; wraps at 2^32
wr_cnt  out  32  completed writes; wraps at 2^32

Behaviour:
- Reset (rst low, async): state INIT, clear pointer = 0, busy = 1, rdy = 0, err = 0, rdata = 0, rd_cnt = 0, wr_cnt = 0.
- States: INIT, IDLE, WAIT, RESP, TURN.
- INIT
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - Once ptr reaches DEPTH-1, the next state is IDLE and busy drops.
  - Total duration: DEPTH cycles.
  - req is ignored but not lost: it is level-held and served from IDLE.
- IDLE
  - On req = 1 at edge t: capture wr, addr, wdata.
  - Load latency counter with (wr ? WR_LAT : RD_LAT) - 1, then go to WAIT.
  - If the loaded value is 0, go directly to RESP.
- WAIT
  - Decrement the counter each cycle; on reaching 0, go to RESP.
  - For reads, issue the array read one cycle before RESP so data is registered on entering RESP.
- RESP (exactly one cycle)
  - rdy = 1, so rdy is high during cycle t+LAT.
  - Read: rdata = word[addr]; rd_cnt += 1.
  - Write: word[addr] = wdata at the edge ending RESP; wr_cnt += 1.
  - Next state: TURN.
- TURN (one cycle): req is ignored, which gives the initiator time to drop or re-issue req. Next state: IDLE.
- Minimum request-to-request spacing: LAT + 2 cycles.
- rdata holds its value until the next completed read; writes do not change it.
- Out of range (addr[63:ADDR_W] != 0):
  - Full latency still applies.
  - RESP asserts rdy and err together.
  - The array is untouched; for reads rdata = 0.
  - Counters still increment.
- Address in range uses addr[ADDR_W-1:0] directly; there is no aliasing.
- Input changes while in WAIT or RESP have no effect, because captured values are used.
- Reset asserted mid-transaction: the transaction is abandoned, rdy never pulses, and the clear restarts from ptr = 0.
- Counter wrap: 32'hFFFF_FFFF + 1 gives 0, with no flag.

Decomposition:
- Package mem_if_pkg:
  - state encoding typedef: INIT, IDLE, WAIT, RESP, TURN
  - DATA_W and ADDR_W defaults
  - latency defaults
- Sub-module mem_responder_ram: single-port DEPTH x DATA_W array with synchronous write and registered synchronous read; no reset on contents.
- The FSM, latency counter, range check and statistics counters live in mem_responder.

Test Plan:
- Reset then idle:
  - rst low 3 cycles, then high: busy = 1 for exactly 8192 cycles, then 0.
  - rdy, err, rd_cnt and wr_cnt stay 0 throughout.
- Read after clear: req, wr = 0, addr = 0x1ABC → rdy high exactly 2 cycles after capture edge, rdata = 0, err = 0, rd_cnt = 1.
- Write/read-back:
  - write addr = 0x0005, wdata = 0xDEAD_BEEF_0123_4567 → rdy 5 cycles after capture, wr_cnt = 1.
  - read addr = 0x0005 → rdata = 0xDEAD_BEEF_0123_4567.
- Out of range:
  - write addr = 0x2000, wdata = 0xFF → rdy and err pulse together.
  - read addr = 0x0000 then returns 0.
  - read addr = 0x1_0000_0000 → rdata = 0, err = 1.
- GUPS loop with `top`:
  - range = 0x1FFF, 10000 cycles.
  - Scoreboard model is zero-initialized and incremented on each write.
  - Every write's wdata equals model value; no err; req always low in the cycle after rdy.
- Async reset mid-write: assert rst low in cycle 3 of WR_LAT → no rdy, busy re-asserts; after clear, the target word reads 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and default geometry/latency for the memory responder.
// Included by the responder top and its word array.
package mem_if_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_TURN
    } state_t;

    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_RD_LAT = 2;
    localparam int unsigned DEF_WR_LAT = 5;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word array: synchronous write, registered synchronous read.
// Contents are not reset; the responder clears them after reset.
module mem_responder_ram
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the req/wr/addr/rdy protocol: fixed read/write
// latency, post-reset array clear, range check and completion counters.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned WR_LAT = DEF_WR_LAT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              req,
    input  logic              wr,
    input  logic [63:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              err,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                oor_q, oor_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [31:0]         rd_cnt_q, rd_cnt_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;

    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;
    logic [CNT_W-1:0]    lat_ld;
    logic [DATA_W-1:0]   rd_word;

    mem_responder_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rd_word = oor_q ? '0 : ram_rdata;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        lat_ld    = wr ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = ptr_q;
                ram_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr[ADDR_W-1:0];
                    oor_d   = |addr[63:ADDR_W];
                    wdata_d = wdata;
                    cnt_d   = lat_ld;
                    state_d = (lat_ld == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Reading on every WAIT cycle leaves the word registered on RESP entry.
                ram_re = ~wr_q;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (wr_q) begin
                    ram_we   = ~oor_q;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    rdata_d  = rd_word;
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end
                state_d = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            oor_q    <= oor_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Read data is presented straight from the array during RESP, then held.
    assign rdata  = (state_q == ST_RESP && !wr_q) ? rd_word : rdata_q;
    assign busy   = (state_q == ST_INIT);
    assign rdy    = (state_q == ST_RESP);
    assign err    = (state_q == ST_RESP) && oor_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: clear timing, latency, read-back,
// out-of-range handling, GUPS-style update loop and mid-transaction reset.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              busy;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [63:0]       addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rdy;
    logic              err;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;

    mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rdy    (rdy),
        .err    (err),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [63:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [DEPTH];
    logic [31:0] exp_rd, exp_wr;
    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [63:0] obs_rdata;
    logic        obs_err, obs_ok, obs_pulse;
    int unsigned obs_lat;

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        exp_rd = '0;
        exp_wr = '0;
        exp_q.delete();
    endtask

    // Drives one transaction, records the expected outcome and captures the observed one.
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
        exp_t        e;
        logic        o;
        logic [12:0] ix;
        o  = (a >> ADDR_W) != 64'd0;
        ix = a[12:0];
        e.is_wr = w;
        e.err   = o;
        e.lat   = w ? WR_LAT : RD_LAT;
        e.rdata = (w || o) ? 64'd0 : model[ix];
        if (w && !o) model[ix] = d;
        if (w) exp_wr = exp_wr + 32'd1;
        else   exp_rd = exp_rd + 32'd1;
        exp_q.push_back(e);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk);
        obs_lat = 0;
        obs_ok  = 1'b0;
        while (!obs_ok && obs_lat < 50) begin
            @(negedge clk);
            obs_lat++;
            obs_ok = (rdy === 1'b1);
            if (!obs_ok) begin
                addr  = {$urandom, $urandom};
                wdata = {$urandom, $urandom};
                wr    = 1'($urandom);
            end
        end
        obs_rdata = rdata;
        obs_err   = err;
        req   = 1'b0;
        addr  = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        wr    = 1'($urandom);
        @(negedge clk);
        obs_pulse = (rdy === 1'b0);
    endtask

    task automatic test_reset();
        int unsigned n;
        logic        quiet;
        rst = 1'b0;
        req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rdy !== 1'b0 || err !== 1'b0 || rdata !== 64'd0 ||
            rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: busy=%b rdy=%b err=%b rdata=%h rd_cnt=%0d wr_cnt=%0d required 1 0 0 0 0 0",
                     busy, rdy, err, rdata, rd_cnt, wr_cnt);
        end
        model_clear();
        rst   = 1'b1;
        n     = 0;
        quiet = 1'b1;
        while (busy === 1'b1 && n < 10000) begin
            n++;
            if (rdy !== 1'b0 || err !== 1'b0 || rd_cnt !== 32'd0 || wr_cnt !== 32'd0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL clear_duration: busy cycles=%0d required=%0d", n, DEPTH);
        end
        checks++;
        if (!quiet || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_quiet: quiet=%b busy=%b required quiet=1 busy=0", quiet, busy);
        end
    endtask

    task automatic test_read_after_clear();
        exp_t e;
        issue(1'b0, 64'h1ABC, 64'd0);
        e = exp_q.pop_front();
        checks++;
        if (!obs_ok || obs_lat != e.lat || !obs_pulse) begin
            failures++;
            $display("FAIL rd_clear_timing: lat=%0d seen=%b pulse=%b required lat=%0d", obs_lat, obs_ok, obs_pulse, e.lat);
        end
        checks++;
        if (obs_rdata !== 64'd0 || obs_err !== 1'b0 || rd_cnt !== 32'd1 || rd_cnt !== exp_rd) begin
            failures++;
            $display("FAIL rd_clear_data: rdata=%h err=%b rd_cnt=%0d required 0 0 1", obs_rdata, obs_err, rd_cnt);
        end
    endtask

    task automatic test_write_readback();
        exp_t e;
        issue(1'b1, 64'h5, 64'hDEAD_BEEF_0123_4567);
        e = exp_q.pop_front();
        checks++;
        if (!obs_ok || obs_lat != e.lat || !obs_pulse || obs_err !== 1'b0 || wr_cnt !== exp_wr) begin
            failures++;
            $display("FAIL wr_timing: lat=%0d seen=%b pulse=%b err=%b wr_cnt=%0d required lat=%0d err=0 wr_cnt=%0d",
                     obs_lat, obs_ok, obs_pulse, obs_err, wr_cnt, e.lat, exp_wr);
        end
        issue(1'b0, 64'h5, 64'd0);
        e = exp_q.pop_front();
        checks++;
        if (!obs_ok || obs_lat != e.lat || obs_rdata !== e.rdata || obs_rdata !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL readback: rdata=%h lat=%0d required rdata=%h lat=%0d", obs_rdata, obs_lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_out_of_range();
        exp_t        e;
        logic [63:0] a_tab [3];
        logic        w_tab [3];
        a_tab[0] = 64'h2000;        w_tab[0] = 1'b1;
        a_tab[1] = 64'h0;           w_tab[1] = 1'b0;
        a_tab[2] = 64'h1_0000_0000; w_tab[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(w_tab[i], a_tab[i], 64'hFF);
            e = exp_q.pop_front();
            checks++;
            if (!obs_ok || obs_lat != e.lat || !obs_pulse || obs_err !== e.err) begin
                failures++;
                $display("FAIL oor_resp[%0d]: lat=%0d seen=%b pulse=%b err=%b required lat=%0d err=%b",
                         i, obs_lat, obs_ok, obs_pulse, obs_err, e.lat, e.err);
            end
            checks++;
            if (!e.is_wr && obs_rdata !== e.rdata) begin
                failures++;
                $display("FAIL oor_rdata[%0d]: rdata=%h required=%h", i, obs_rdata, e.rdata);
            end else if (e.is_wr && obs_rdata !== 64'hDEAD_BEEF_0123_4567) begin
                failures++;
                $display("FAIL rdata_hold: rdata=%h required=%h", obs_rdata, 64'hDEAD_BEEF_0123_4567);
            end
        end
        checks++;
        if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
            failures++;
            $display("FAIL oor_counts: rd_cnt=%0d wr_cnt=%0d required %0d %0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
    endtask

    task automatic test_gups();
        exp_t        e;
        logic [63:0] a, v;
        int unsigned bad = 0;
        for (int i = 0; i < 900; i++) begin
            a = (i % 2 == 0) ? 64'($urandom_range(0, 63)) : 64'($urandom_range(0, 8191));
            issue(1'b0, a, 64'd0);
            e = exp_q.pop_front();
            v = obs_rdata;
            checks++;
            if (!obs_ok || obs_lat != e.lat || !obs_pulse || obs_err !== 1'b0 || obs_rdata !== e.rdata) begin
                failures++;
                if (bad < 5) $display("FAIL gups_read: addr=%h rdata=%h err=%b lat=%0d required rdata=%h err=0 lat=%0d",
                                      a, obs_rdata, obs_err, obs_lat, e.rdata, e.lat);
                bad++;
            end
            issue(1'b1, a, e.rdata + 64'd1);
            e = exp_q.pop_front();
            checks++;
            if (!obs_ok || obs_lat != e.lat || !obs_pulse || obs_err !== 1'b0 || obs_rdata !== v) begin
                failures++;
                if (bad < 5) $display("FAIL gups_write: addr=%h err=%b lat=%0d rdata=%h required err=0 lat=%0d rdata=%h",
                                      a, obs_err, obs_lat, obs_rdata, e.lat, v);
                bad++;
            end
        end
        checks++;
        if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
            failures++;
            $display("FAIL gups_counts: rd_cnt=%0d wr_cnt=%0d required %0d %0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
    endtask

    task automatic test_reset_mid_write();
        exp_t        e;
        int unsigned n;
        logic        saw_rdy = 1'b0;
        issue(1'b1, 64'h10, 64'h1234_5678);
        e = exp_q.pop_front();
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 64'h10; wdata = 64'hBAD0_BAD0;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            if (rdy !== 1'b0) saw_rdy = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rdy !== 1'b0 || wr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midreset_state: busy=%b rdy=%b wr_cnt=%0d required 1 0 0", busy, rdy, wr_cnt);
        end
        repeat (3) begin
            @(negedge clk);
            if (rdy !== 1'b0) saw_rdy = 1'b1;
        end
        req = 1'b0;
        model_clear();
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            n++;
            if (rdy !== 1'b0) saw_rdy = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_rdy || n != DEPTH) begin
            failures++;
            $display("FAIL midreset_clear: rdy_seen=%b busy cycles=%0d required rdy_seen=0 cycles=%0d", saw_rdy, n, DEPTH);
        end
        issue(1'b0, 64'h10, 64'd0);
        e = exp_q.pop_front();
        checks++;
        if (!obs_ok || obs_rdata !== e.rdata || obs_rdata !== 64'd0 || rd_cnt !== 32'd1) begin
            failures++;
            $display("FAIL midreset_readback: rdata=%h seen=%b rd_cnt=%0d required rdata=0 rd_cnt=1", obs_rdata, obs_ok, rd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_clear();
        test_write_readback();
        test_out_of_range();
        test_gups();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
